// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Also holds the two's-complement helpers used for operand magnitude and sign fix-up.
package div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam logic [XLEN-1:0] DIV0_QUO = 32'hFFFFFFFF;
  localparam logic [XLEN-1:0] INT_MIN  = 32'h80000000;

  function automatic logic [XLEN-1:0] twosNeg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // INT_MIN maps onto itself, which is exactly its unsigned magnitude
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? twosNeg(x) : x;
  endfunction

endpackage

// File: rtl/div_step32.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor
// magnitude in 33 bits, and keep or restore the partial remainder.
module div_step32
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, div_i};

  assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_seq32s.sv
// Iterative signed 32-bit restoring divider, one quotient bit per clock.
// Define DIV_SPECIAL_FAST_EN to finish div-by-zero, overflow and divide-by-one at accept.
module div_seq32s #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            busy
);

  import div_pkg::*;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  remAcc_q;
  logic [XLEN-1:0]  quoAcc_q;
  logic [XLEN-1:0]  divisorMag_q;
  logic [XLEN-1:0]  dividend_q;
  logic             signQ_q;
  logic             signR_q;
  logic             divZero_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic             outValid_q;

  logic [XLEN-1:0]  remStep;
  logic [XLEN-1:0]  quoStep;
  logic [XLEN-1:0]  fixQuo;
  logic [XLEN-1:0]  fixRem;
  logic             fastHit;
  logic [XLEN-1:0]  fastQuo;
  logic [XLEN-1:0]  fastRem;

  div_step32 uStep (
    .rem_i (remAcc_q),
    .quo_i (quoAcc_q),
    .div_i (divisorMag_q),
    .rem_o (remStep),
    .quo_o (quoStep)
  );

  // Overflow (INT_MIN / -1) falls out naturally: unsigned 2^31 / 1 with a positive sign.
  always_comb begin
    fixQuo = signQ_q ? twosNeg(quoAcc_q) : quoAcc_q;
    fixRem = signR_q ? twosNeg(remAcc_q) : remAcc_q;
    if (divZero_q) begin
      fixQuo = DIV0_QUO;
      fixRem = dividend_q;
    end
  end

`ifdef DIV_SPECIAL_FAST_EN
  always_comb begin
    fastHit = 1'b0;
    fastQuo = op1;
    fastRem = '0;
    if (op2 == '0) begin
      fastHit = 1'b1;
      fastQuo = DIV0_QUO;
      fastRem = op1;
    end else if (op1 == INT_MIN && op2 == '1) begin
      fastHit = 1'b1;
      fastQuo = INT_MIN;
    end else if (op2 == XLEN'(1)) begin
      fastHit = 1'b1;
    end
  end
`else
  assign fastHit = 1'b0;
  assign fastQuo = '0;
  assign fastRem = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      remAcc_q     <= '0;
      quoAcc_q     <= '0;
      divisorMag_q <= '0;
      dividend_q   <= '0;
      signQ_q      <= 1'b0;
      signR_q      <= 1'b0;
      divZero_q    <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      outValid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (fastHit) begin
              quo_q      <= fastQuo;
              rem_q      <= fastRem;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              remAcc_q     <= '0;
              quoAcc_q     <= absVal(op1);
              divisorMag_q <= absVal(op2);
              dividend_q   <= op1;
              signQ_q      <= op1[XLEN-1] ^ op2[XLEN-1];
              signR_q      <= op1[XLEN-1];
              divZero_q    <= (op2 == '0);
              cnt_q        <= '0;
              state_q      <= CALC;
            end
          end
        end
        CALC: begin
          remAcc_q <= remStep;
          quoAcc_q <= quoStep;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quo_q      <= fixQuo;
          rem_q      <= fixRem;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign out_valid = outValid_q;
  assign quo       = quo_q;
  assign rem       = rem_q;

endmodule

// File: tb/tb_div_seq32s.sv
// Directed bench for div_seq32s: signed results, special cases, latency,
// backpressure and mid-operation reset. Honours DIV_SPECIAL_FAST_EN for latency.
module tb_div_seq32s;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  localparam int FULL_LAT = 34;
`ifdef DIV_SPECIAL_FAST_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 34;
`endif
  localparam int MAX_WAIT = 100;

  always #5 clk = ~clk;

  div_seq32s dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [31:0] expR, input int expLat);
    int lat;
    in_valid  = 1'b1;
    op1       = a;
    op2       = b;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_quo"}, quo, expQ);
    checkOutput({tag, "_rem"}, rem, expR);
    @(posedge clk); #1;
    checkOutput({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    logic signed [31:0] sa, sb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_busy",      {31'b0, busy},      32'd0);
    checkOutput("rst_quo",       quo,                32'd0);
    checkOutput("rst_rem",       rem,                32'd0);
    rst = 1'b0;

    applyStimulus("p100_p7",   32'd100,        32'd7,          32'd14,         32'd2,          FULL_LAT);
    applyStimulus("n100_p7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   FULL_LAT);
    applyStimulus("n100_n7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   FULL_LAT);
    applyStimulus("p100_n7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          FULL_LAT);
    applyStimulus("div0_pos",  32'd7,          32'd0,          32'hFFFFFFFF,   32'd7,          FAST_LAT);
    applyStimulus("div0_neg",  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   FAST_LAT);
    applyStimulus("overflow",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          FAST_LAT);
    applyStimulus("by_one",    32'd12345,      32'd1,          32'd12345,      32'd0,          FAST_LAT);
    applyStimulus("neg1_by1",  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          FAST_LAT);
    applyStimulus("min_by2",   32'h80000000,   32'd2,          32'hC0000000,   32'd0,          FULL_LAT);
    applyStimulus("small_pos", 32'd5,          32'd10,         32'd0,          32'd5,          FULL_LAT);
    applyStimulus("small_neg", 32'hFFFFFFFB,   32'd10,         32'd0,          32'hFFFFFFFB,   FULL_LAT);
    applyStimulus("max_min",   32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   FULL_LAT);
    applyStimulus("min_min",   32'h80000000,   32'h80000000,   32'd1,          32'd0,          FULL_LAT);

    // Backpressure: result must hold and new requests must be ignored in DONE.
    in_valid = 1'b1; op1 = 32'd1000; op2 = 32'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("bp_lat", 32'(lat), 32'(FULL_LAT));
    checkOutput("bp_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op1 = 32'(i + 2); op2 = 32'd1;
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_hold_quo",   quo,                32'd333);
      checkOutput("bp_hold_rem",   rem,                32'd1);
      checkOutput("bp_in_ready",   {31'b0, in_ready},  32'd0);
    end
    in_valid = 1'b1; op1 = 32'd50; op2 = 32'd5; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, in_ready},  32'd1);
    checkOutput("bp_release_quo",   quo,                32'd333);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("bp_next_lat", 32'(lat), 32'(FULL_LAT));
    checkOutput("bp_next_quo", quo, 32'd10);
    checkOutput("bp_next_rem", rem, 32'd0);
    @(posedge clk); #1;

    // Reset while CALC has counted to 15.
    in_valid = 1'b1; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("mid_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_busy_off",  {31'b0, busy},      32'd0);
    checkOutput("mid_quo",       quo,                32'd0);
    checkOutput("mid_rem",       rem,                32'd0);
    applyStimulus("after_rst", 32'h7FFFFFFF, 32'd2, 32'h3FFFFFFF, 32'd1, FULL_LAT);

    // Random pairs against the language's truncating signed division.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd3;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      sa = ra;
      sb = rb;
      applyStimulus("rand", ra, rb, 32'(sa / sb), 32'(sa % sb), (rb == 32'd1) ? FAST_LAT : FULL_LAT);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
